// File: rtl/bitty_wbm_pkg.sv
// Shared types and constants for the bitty Wishbone classic master.
// Imported by bitty_wb_master and bitty_wbm_timeout.
package bitty_wbm_pkg;

   localparam int WB_DW = 32;
   localparam int WB_AW = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Low BITS/8 byte lanes are active; the CPU side never does sub-word access.
   function automatic logic [3:0] sel_mask(input int bits);
      logic [3:0] mask;
      case (bits)
         32'sd8:  mask = 4'b0001;
         32'sd16: mask = 4'b0011;
         default: mask = 4'b1111;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/bitty_wbm_timeout.sv
// Bus-cycle watchdog for bitty_wb_master, only instantiated when
// BITTY_WBM_TIMEOUT_EN is defined.
module bitty_wbm_timeout
   import bitty_wbm_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_r;

   // Counts completed BUS cycles and saturates on the last allowed one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (en && (cnt_r != LAST)) begin
         cnt_r <= cnt_r + 1'b1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // High during the TIMEOUT-th BUS cycle, so the transfer ends at its closing edge.
   assign expired = en && (cnt_r == LAST);

endmodule

// File: rtl/bitty_wb_master.sv
// Wishbone B4 classic single-transfer initiator for the bitty core.
// Optional bus watchdog enabled by defining BITTY_WBM_TIMEOUT_EN.
module bitty_wb_master
   import bitty_wbm_pkg::*;
#(
   parameter int BITS    = 16,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [BITS-1:0]   req_wdata_i,
   output logic              rsp_valid_o,
   output logic [BITS-1:0]   rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [3:0]        wbm_sel_o,
   output logic [WB_AW-1:0]  wbm_adr_o,
   output logic [WB_DW-1:0]  wbm_dat_o,
   input  logic [WB_DW-1:0]  wbm_dat_i,
   input  logic              wbm_ack_i,
   input  logic              wbm_err_i
);

   state_t            state_r, state_nxt_s;
   logic              cyc_r, cyc_nxt_s;
   logic              we_r, we_nxt_s;
   logic [3:0]        sel_r, sel_nxt_s;
   logic [WB_AW-1:0]  adr_r, adr_nxt_s;
   logic [WB_DW-1:0]  dat_r, dat_nxt_s;
   logic              rsp_valid_r, rsp_valid_nxt_s;
   logic              rsp_err_r, rsp_err_nxt_s;
   logic [BITS-1:0]   rdata_r, rdata_nxt_s;
   logic              accept_s, timeout_s, term_s, term_err_s;
   logic              unused_s;

   assign accept_s = (state_r == ST_IDLE) && req_valid_i;

`ifdef BITTY_WBM_TIMEOUT_EN
   bitty_wbm_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_n_i),
      .clr     (accept_s),
      .en      (state_r == ST_BUS),
      .expired (timeout_s)
   );
`else
   assign timeout_s = 1'b0;
`endif

   // err beats ack; a late ack/err on the timeout edge beats the timeout.
   assign term_err_s = wbm_err_i || (timeout_s && !wbm_ack_i);
   assign term_s     = wbm_ack_i || wbm_err_i || timeout_s;
   assign unused_s   = ^{wbm_dat_i, (TIMEOUT > 0)};

   // State register.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_nxt_s = ST_BUS;
            else          state_nxt_s = ST_IDLE;
         end
         ST_BUS: begin
            if (term_s) state_nxt_s = ST_RESP;
            else        state_nxt_s = ST_BUS;
         end
         ST_RESP: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Next values for the registered bus and response outputs.
   always_comb begin
      cyc_nxt_s       = cyc_r;
      we_nxt_s        = we_r;
      sel_nxt_s       = sel_r;
      adr_nxt_s       = adr_r;
      dat_nxt_s       = dat_r;
      rsp_valid_nxt_s = 1'b0;
      rsp_err_nxt_s   = 1'b0;
      rdata_nxt_s     = rdata_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               cyc_nxt_s = 1'b1;
               we_nxt_s  = req_we_i;
               sel_nxt_s = sel_mask(BITS);
               adr_nxt_s = WB_AW'(req_addr_i);
               dat_nxt_s = WB_DW'(req_wdata_i);
            end else begin
               cyc_nxt_s = 1'b0;
            end
         end
         ST_BUS: begin
            if (term_s) begin
               cyc_nxt_s       = 1'b0;
               rsp_valid_nxt_s = 1'b1;
               rsp_err_nxt_s   = term_err_s;
               rdata_nxt_s     = (!we_r && !term_err_s) ? wbm_dat_i[BITS-1:0] : '0;
            end else begin
               cyc_nxt_s = 1'b1;
            end
         end
         ST_RESP: cyc_nxt_s = 1'b0;
         default: cyc_nxt_s = 1'b0;
      endcase
   end

   // Output registers; reset aborts any transfer in flight.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         cyc_r       <= 1'b0;
         we_r        <= 1'b0;
         sel_r       <= 4'b0000;
         adr_r       <= '0;
         dat_r       <= '0;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rdata_r     <= '0;
      end else begin
         cyc_r       <= cyc_nxt_s;
         we_r        <= we_nxt_s;
         sel_r       <= sel_nxt_s;
         adr_r       <= adr_nxt_s;
         dat_r       <= dat_nxt_s;
         rsp_valid_r <= rsp_valid_nxt_s;
         rsp_err_r   <= rsp_err_nxt_s;
         rdata_r     <= rdata_nxt_s;
      end
   end

   assign req_ready_o = (state_r == ST_IDLE);
   assign wbm_cyc_o   = cyc_r;
   assign wbm_stb_o   = cyc_r;
   assign wbm_we_o    = we_r;
   assign wbm_sel_o   = sel_r;
   assign wbm_adr_o   = adr_r;
   assign wbm_dat_o   = dat_r;
   assign rsp_valid_o = rsp_valid_r;
   assign rsp_err_o   = rsp_err_r;
   assign rsp_rdata_o = rdata_r;

endmodule

// File: tb/tb_bitty_wb_master.sv
// Scoreboard bench for bitty_wb_master (BITS=16, TIMEOUT=8); covers the
// BITTY_WBM_TIMEOUT_EN build when that macro is defined.
module tb_bitty_wb_master;

   localparam int M_ACK   = 0;
   localparam int M_ERR   = 1;
   localparam int M_NEVER = 2;

   typedef struct packed {
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we;
   logic [31:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_ready_o, rsp_valid_o, rsp_err_o;
   logic [15:0] rsp_rdata_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic [31:0] slv_dat;
   logic        wbm_ack_i, wbm_err_i;

   int          tests = 0;
   int          fails = 0;
   int          edge_cnt = 0;
   int          rsp_cnt = 0;
   int          slv_mode = M_ACK;
   int          slv_wait = 0;
   logic        stray_ack = 1'b0;
   exp_t        sb_q[$];
   exp_t        exp_e;
   logic        prev_rv = 1'b0;

   int          cyc_run = 0;
   int          last_run = 0;
   int          cyc_starts = 0;
   logic        unstable = 1'b0;
   logic [31:0] cap_adr, cap_dat;
   logic [3:0]  cap_sel;
   logic        cap_we;

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   bitty_wb_master #(
      .BITS    (16),
      .ADDR_W  (32),
      .TIMEOUT (8)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_n_i  (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready_o),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .wbm_cyc_o   (wbm_cyc_o),
      .wbm_stb_o   (wbm_stb_o),
      .wbm_we_o    (wbm_we_o),
      .wbm_sel_o   (wbm_sel_o),
      .wbm_adr_o   (wbm_adr_o),
      .wbm_dat_o   (wbm_dat_o),
      .wbm_dat_i   (slv_dat),
      .wbm_ack_i   (wbm_ack_i),
      .wbm_err_i   (wbm_err_i)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request and holds it until accepted; reports the accept edge.
   task automatic issue(input logic we, input logic [31:0] adr, input logic [15:0] wd,
                        output int acc_edge);
      logic done;
      done      = 1'b0;
      acc_edge  = -1;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = adr;
      req_wdata = wd;
      for (int n = 0; n < 50 && !done; n++) begin
         if (req_ready_o) begin
            tick();
            acc_edge = edge_cnt;
            done     = 1'b1;
         end else begin
            tick();
         end
      end
      req_valid = 1'b0;
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL issue_accept: got no acceptance within 50 cycles, required acceptance");
      end
   endtask

   task automatic wait_rsp(input int target);
      for (int n = 0; n < 300 && rsp_cnt < target; n++) tick();
      tick();
      check("rsp_count", rsp_cnt, target);
   endtask

   // Wishbone slave: acks after slv_wait extra cycles; stray_ack injects a bare ack.
   initial begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      forever begin
         int bus_wait;
         @(posedge clk);
         #2;
         if (wbm_cyc_o && wbm_stb_o && slv_mode != M_NEVER) begin
            if (bus_wait >= slv_wait) begin
               wbm_ack_i = 1'b1;
               wbm_err_i = (slv_mode == M_ERR);
               bus_wait  = 0;
            end else begin
               wbm_ack_i = 1'b0;
               wbm_err_i = 1'b0;
               bus_wait++;
            end
         end else begin
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            bus_wait  = 0;
         end
         wbm_ack_i = wbm_ack_i | stray_ack;
      end
   end

   // Bus observer: cycle length, attributes at cycle start and their stability.
   always @(negedge clk) begin
      if (wbm_cyc_o) begin
         if (cyc_run == 0) begin
            cap_adr  = wbm_adr_o;
            cap_dat  = wbm_dat_o;
            cap_sel  = wbm_sel_o;
            cap_we   = wbm_we_o;
            unstable = 1'b0;
            cyc_starts++;
         end else if ({wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o}
                      != {cap_adr, cap_dat, cap_sel, cap_we, 1'b1}) begin
            unstable = 1'b1;
         end
         cyc_run++;
      end else if (cyc_run != 0) begin
         last_run = cyc_run;
         cyc_run  = 0;
      end
   end

   // Response monitor: pops the scoreboard on every rsp_valid strobe.
   always @(negedge clk) begin
      if (rsp_valid_o) begin
         rsp_cnt++;
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=%h err=%b, required no response",
                     rsp_rdata_o, rsp_err_o);
         end else begin
            exp_e = sb_q.pop_front();
            check("rsp_rdata", {16'h0000, rsp_rdata_o}, {16'h0000, exp_e.rdata});
            check("rsp_err", {31'd0, rsp_err_o}, {31'd0, exp_e.err});
            check("rsp_ready_low", {31'd0, req_ready_o}, 32'd0);
            check("rsp_one_cycle", {31'd0, prev_rv}, 32'd0);
         end
      end
      prev_rv = rsp_valid_o;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion, required $finish before 200000");
      $fatal(1);
   end

   initial begin
      int a1, a2, base;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 16'h0;
      slv_dat   = 32'h0;
      repeat (3) tick();

      // Reset values
      check("rst_ready", {31'd0, req_ready_o}, 32'd1);
      check("rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
      check("rst_we_sel", {27'd0, wbm_we_o, wbm_sel_o}, 32'd0);
      check("rst_adr", wbm_adr_o, 32'd0);
      check("rst_dat", wbm_dat_o, 32'd0);
      check("rst_rsp", {14'd0, rsp_valid_o, rsp_err_o, rsp_rdata_o}, 32'd0);
      rst_n = 1'b1;
      tick();

      // 1: read, ack in second BUS cycle
      slv_mode = M_ACK;
      slv_wait = 1;
      slv_dat  = 32'hDEAD_BEEF;
      sb_q.push_back('{rdata: 16'hBEEF, err: 1'b0});
      issue(1'b0, 32'h3000_0010, 16'h0000, a1);
      wait_rsp(1);
      check("t1_cyc_len", last_run, 32'd2);
      check("t1_sel", {28'd0, cap_sel}, 32'h3);
      check("t1_adr", cap_adr, 32'h3000_0010);
      check("t1_we", {31'd0, cap_we}, 32'd0);
      check("t1_stable", {31'd0, unstable}, 32'd0);

      // 2: write, zero-wait ack
      slv_wait = 0;
      sb_q.push_back('{rdata: 16'h0000, err: 1'b0});
      issue(1'b1, 32'h0000_0004, 16'h1234, a1);
      wait_rsp(2);
      check("t2_dat", cap_dat, 32'h0000_1234);
      check("t2_we", {31'd0, cap_we}, 32'd1);
      check("t2_cyc_len", last_run, 32'd1);

      // 3: err and ack together on a read
      slv_mode = M_ERR;
      sb_q.push_back('{rdata: 16'h0000, err: 1'b1});
      issue(1'b0, 32'h0000_0008, 16'h0000, a1);
      wait_rsp(3);
      check("t3_cyc_len", last_run, 32'd1);

      // 4: silent slave
      slv_mode = M_NEVER;
`ifdef BITTY_WBM_TIMEOUT_EN
      sb_q.push_back('{rdata: 16'h0000, err: 1'b1});
      issue(1'b0, 32'h0000_000C, 16'h0000, a1);
      wait_rsp(4);
      check("t4_timeout_len", last_run, 32'd8);
      base = rsp_cnt;
      issue(1'b0, 32'h0000_0010, 16'h0000, a1);
      repeat (3) tick();
`else
      base = rsp_cnt;
      issue(1'b0, 32'h0000_000C, 16'h0000, a1);
      repeat (100) tick();
      check("t4_cyc_held", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd3);
      check("t4_no_rsp", rsp_cnt, base);
`endif

      // 5: reset during BUS, then a stray ack
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t5_cyc_stb_low", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
      check("t5_ready", {31'd0, req_ready_o}, 32'd1);
      stray_ack = 1'b1;
      tick();
      stray_ack = 1'b0;
      repeat (3) tick();
      check("t5_idle_after_ack", {30'd0, req_ready_o, wbm_cyc_o}, 32'd2);
      check("t5_no_rsp", rsp_cnt, base);

      // 6: back-to-back with held req_valid
      slv_mode = M_ACK;
      slv_wait = 0;
      slv_dat  = 32'h1111_5A5A;
      sb_q.push_back('{rdata: 16'h5A5A, err: 1'b0});
      sb_q.push_back('{rdata: 16'h0000, err: 1'b0});
      base = cyc_starts;
      issue(1'b0, 32'h0000_0020, 16'h0000, a1);
      issue(1'b1, 32'h0000_0024, 16'hCAFE, a2);
      wait_rsp(base == cyc_starts ? rsp_cnt : rsp_cnt);
      for (int n = 0; n < 20 && sb_q.size() != 0; n++) tick();
      check("t6_accept_gap", a2 - a1, 32'd3);
      check("t6_two_cycles", cyc_starts - base, 32'd2);
      check("t6_last_dat", cap_dat, 32'h0000_CAFE);

      check("sb_empty", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
